fifo_uart_tx: RTL and testbench

//   Downstream consumer of the 8-bit synchronous FIFO. Drains bytes from the FIFO read

---
 rtl/fifo_uart_tx_if.sv | 19 +
 rtl/fifo_uart_tx.sv | 129 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read port of the 8-bit synchronous FIFO as seen by its single consumer.
// master = the reader (drives pop), slave = the FIFO (drives empty/dout).
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_pop;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_pop
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the FIFO read port and sends each as an 8N1/8N2 UART frame,
// LSB first. All outputs are decoded from registered state only.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          stop_cnt_reg, stop_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          baud_last;
  logic          can_start;

  assign baud_last = (baud_cnt_reg == BAUD_LAST);
  assign can_start = enable && !fifo.fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    case (state_reg)
      IDLE: begin
        if (can_start) state_next = POP;
      end
      POP: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next    = fifo.fifo_dout;
        baud_cnt_next = '0;
        state_next    = START;
      end
      START: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            stop_cnt_next = 1'b0;
            state_next    = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          // enable and empty are only consulted here and in IDLE, so a frame is never cut short
          if (stop_cnt_reg == STOP_LAST) begin
            state_next = can_start ? POP : IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: tx = 1'b1;
    endcase
  end

  assign fifo.fifo_pop = (state_reg == POP);
  assign busy          = (state_reg != IDLE);
  assign byte_done     = (state_reg == STOP) && baud_last && (stop_cnt_reg == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: two transmitters (1 and 2 stop bits) fed by behavioural FIFOs; every frame
// is checked cycle by cycle against the ideal UART waveform for the byte popped.
module tb_fifo_uart_tx;
  localparam int C  = 4;
  localparam int F1 = (9 + 1) * C;
  localparam int F2 = (9 + 2) * C;

  logic clk;
  logic rst;
  logic en1, en2;
  logic tx1, busy1, bd1;
  logic tx2, busy2, bd2;
  logic       push_en1, push_en2;
  logic [7:0] push_data1, push_data2;

  fifo_uart_tx_if f1 ();
  fifo_uart_tx_if f2 ();

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst), .enable(en1), .fifo(f1),
    .tx(tx1), .busy(busy1), .byte_done(bd1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst), .enable(en2), .fifo(f2),
    .tx(tx2), .busy(busy2), .byte_done(bd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFOs: dout valid the cycle after pop, empty updates after the edge
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] sent1[0:1023];
  logic [7:0] sent2[0:63];
  int wr1 = 0;
  int wr2 = 0;

  always @(posedge clk) begin
    f1.fifo_empty <= (q1.size() - ((f1.fifo_pop && q1.size() > 0) ? 1 : 0)
                      + (push_en1 ? 1 : 0)) == 0;
    if (f1.fifo_pop && q1.size() > 0) begin
      f1.fifo_dout <= q1[0];
      sent1[wr1]   <= q1[0];
      wr1          <= wr1 + 1;
      void'(q1.pop_front());
    end
    if (push_en1) q1.push_back(push_data1);
  end

  always @(posedge clk) begin
    f2.fifo_empty <= (q2.size() - ((f2.fifo_pop && q2.size() > 0) ? 1 : 0)
                      + (push_en2 ? 1 : 0)) == 0;
    if (f2.fifo_pop && q2.size() > 0) begin
      f2.fifo_dout <= q2[0];
      sent2[wr2]   <= q2[0];
      wr2          <= wr2 + 1;
      void'(q2.pop_front());
    end
    if (push_en2) q2.push_back(push_data2);
  end

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int k1 = -1, rd1 = 0, pops1 = 0, pop_cyc1 = -100, frames1 = 0, bd1_cnt = 0;
  int k2 = -1, rd2 = 0, pops2 = 0, frames2 = 0, bd2_cnt = 0;
  logic [7:0] cur1, rx1, last_rx1, cur2, rx2;
  int starts1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ideal line level k cycles into a frame: start bit, 8 data bits LSB first, stop
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < C) return 1'b0;
    if (k < 9 * C) return b[(k - C) / C];
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (f1.fifo_pop) begin
      check("pop1_nonempty", f1.fifo_empty, 0);
      pops1++;
      pop_cyc1 = cyc_n;
    end
    if (f2.fifo_pop) begin
      check("pop2_nonempty", f2.fifo_empty, 0);
      pops2++;
    end
    if (bd1) bd1_cnt++;
    if (bd2) bd2_cnt++;
    if (rst) begin
      k1 = -1; rd1 = wr1;
      k2 = -1; rd2 = wr2;
    end else begin
      if (k1 < 0) begin
        if (tx1 == 1'b0) begin
          check("frame1_src", rd1 < wr1, 1);
          check("start_latency", cyc_n - pop_cyc1, 2);
          cur1 = sent1[rd1];
          rd1++;
          k1 = 0;
          rx1 = '0;
          starts1.push_back(cyc_n);
        end else begin
          check("idle1_done", bd1, 0);
        end
      end
      if (k1 >= 0) begin
        check("tx1", tx1, exp_tx(k1, cur1));
        check("done1", bd1, k1 == F1 - 1);
        check("busy1", busy1, 1);
        if (k1 >= C && k1 < 9 * C && (k1 % C) == C / 2) rx1[3'((k1 - C) / C)] = tx1;
        k1++;
        if (k1 == F1) begin
          check("rx1", rx1, cur1);
          last_rx1 = rx1;
          frames1++;
          k1 = -1;
          $display("[TB] dut1 frame %0d byte=%02h", frames1, rx1);
        end
      end
      if (k2 < 0) begin
        if (tx2 == 1'b0) begin
          check("frame2_src", rd2 < wr2, 1);
          cur2 = sent2[rd2];
          rd2++;
          k2 = 0;
          rx2 = '0;
        end
      end
      if (k2 >= 0) begin
        check("tx2", tx2, exp_tx(k2, cur2));
        check("done2", bd2, k2 == F2 - 1);
        if (k2 >= C && k2 < 9 * C && (k2 % C) == C / 2) rx2[3'((k2 - C) / C)] = tx2;
        k2++;
        if (k2 == F2) begin
          check("rx2", rx2, cur2);
          frames2++;
          k2 = -1;
          $display("[TB] dut2 frame %0d byte=%02h", frames2, rx2);
        end
      end
    end
  endtask

  task automatic push1(input logic [7:0] b);
    push_en1 = 1'b1;
    push_data1 = b;
    tick();
    push_en1 = 1'b0;
  endtask

  task automatic wait_frames1(input int n, input int budget);
    int i = 0;
    while (frames1 < n && i < budget) begin
      tick();
      i++;
    end
    check("wait_frames1", frames1 >= n, 1);
  endtask

  task automatic wait_k1(input int kmin, input int budget);
    int i = 0;
    while (k1 < kmin && i < budget) begin
      tick();
      i++;
    end
    check("wait_k1", k1 >= kmin, 1);
  endtask

  initial begin
    int p0;
    int i;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b1;
    push_en1 = 1'b0; push_en2 = 1'b0; push_data1 = '0; push_data2 = '0;

    // 1: reset, then enabled with an empty FIFO
    tick(); tick();
    check("rst_tx", tx1, 1);
    check("rst_pop", f1.fifo_pop, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", bd1, 0);
    rst = 1'b0; en1 = 1'b1;
    repeat (5) tick();
    check("idle_busy", busy1, 0);
    check("idle_pops", pops1, 0);

    // 2: single byte
    push1(8'hA5);
    wait_frames1(1, 80);
    check("a5_pops", pops1, 1);
    check("a5_done_cnt", bd1_cnt, 1);
    tick();
    check("a5_busy_after", busy1, 0);

    // 3: three back-to-back frames
    starts1.delete();
    push1(8'h01); push1(8'h02); push1(8'h03);
    wait_frames1(4, 250);
    check("b2b_pops", pops1, 4);
    check("b2b_starts", starts1.size(), 3);
    if (starts1.size() == 3) begin
      check("b2b_gap0", starts1[1] - starts1[0], F1 + 2);
      check("b2b_gap1", starts1[2] - starts1[1], F1 + 2);
    end
    tick();
    check("b2b_q_empty", q1.size(), 0);
    check("b2b_empty_flag", f1.fifo_empty, 1);
    check("b2b_done_cnt", bd1_cnt, 4);

    // 4: enable gating, dropped mid-frame
    en1 = 1'b0;
    push1(8'h3C); push1(8'hC3);
    repeat (10) tick();
    check("dis_pops", pops1, 4);
    check("dis_tx", tx1, 1);
    check("dis_busy", busy1, 0);
    en1 = 1'b1;
    wait_k1(C + 2, 20);
    en1 = 1'b0;
    wait_frames1(5, 100);
    repeat (20) tick();
    check("dis_one_pop", pops1, 5);
    check("dis_left", q1.size(), 1);
    check("dis_busy_end", busy1, 0);
    en1 = 1'b1;
    wait_frames1(6, 100);

    // 5: reset mid-DATA of 0x55 with 0x66 queued
    push1(8'h55); push1(8'h66);
    wait_k1(C + 6, 40);
    p0 = pops1;
    rst = 1'b1;
    tick();
    check("mid_rst_tx", tx1, 1);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_pops", pops1, p0);
    rst = 1'b0;
    wait_frames1(7, 100);
    check("post_rst_byte", last_rx1, 8'h66);
    check("post_rst_pops", pops1, p0 + 1);

    // 6: two stop bits
    push_en2 = 1'b1; push_data2 = 8'hFF;
    tick();
    push_en2 = 1'b0;
    i = 0;
    while (frames2 < 1 && i < 100) begin
      tick();
      i++;
    end
    check("s2_frame", frames2, 1);
    check("s2_done_cnt", bd2_cnt, 1);
    tick();
    check("s2_busy_after", busy2, 0);
    check("s2_pops", pops2, 1);

    // Randomized traffic with enable toggling
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) push1(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) en1 = ~en1;
      repeat ($urandom_range(1, 80)) tick();
    end
    en1 = 1'b1;
    i = 0;
    while ((q1.size() != 0 || busy1 || k1 >= 0) && i < 2000) begin
      tick();
      i++;
    end
    repeat (3) tick();
    check("rand_drained", q1.size(), 0);
    check("rand_frames", frames1, pops1 - 1);
    check("rand_done_cnt", bd1_cnt, frames1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
